tick_scheduler: RTL and testbench
=================================

# tick_scheduler

Multi-channel timer scheduler built on a shared synchronous decade prescaler. The prescaler divides `clk` by 10, 100 and 1000; with a 1 kHz clock the /1000 strobe is the 1 Hz tick. `NCH` requesters arm, re-arm or stop countdown channels through one round-robin-arbitrated configuration port. Each channel counts one selected prescaler strobe and pulses `expire` when its period elapses. The block sits between the system timebase and the control FSMs that need ms/10 ms/100 ms/1 s timeouts.

## Interface
- `NCH`, 4: number of requester/timer channels (2..8).
- `CNT_W`, 16: period counter width.
- `clk` in 1: single system clock; all state clocked here, no derived clocks.
- `reset` in 1: reset, synchronous, active-high; clock clk.
- `req` in NCH: per-channel configuration request; held with its fields until `gnt`.
- `req_period` in NCH*CNT_W: channel i period at `[i*CNT_W +: CNT_W]`, in strobes.
- `req_scale` in NCH*2: channel i strobe select at `[2i +: 2]`:
  - 0: every clk.
  - 1: /10.
  - 2: /100.
  - 3: /1000.
- `req_mode` in NCH: 1 = periodic, 0 = one-shot.
- `req_stop` in NCH: 1 = stop the channel (other fields ignored).
- `gnt` out NCH: registered one-hot pulse, one cycle; the request was accepted.
- `expire` out NCH: registered one-cycle pulse per elapsed period.
- `busy` out NCH: channel armed (active flag).
- `tick` out 4: prescaler strobes `{t1000, t100, t10, t1}`, decoded from prescaler registers.

## Operation
- **Prescaler**
  - Three 4-bit BCD digits d0, d1, d2, all clocked by `clk`. d0 increments every edge and wraps 9→0.
  - d1 advances only on edges where d0==9. d2 advances only on edges where d0==d1==9.
  - Strobes:
    - t1 = 1 always.
    - t10 = (d0==9).
    - t100 = t10 & (d1==9).
    - t1000 = t100 & (d2==9).
  - The prescaler is free-running from reset. It is never reset by channel activity.
- **Arbiter**
  - Round-robin pointer `ptr`; candidates are searched in the order ptr, ptr+1, …, wrapping at NCH.
  - At each edge, the first candidate with `req` high is accepted:
    - `gnt[i]` is high for the following cycle.
    - `ptr` becomes i+1 mod NCH.
  - At most one acceptance per edge.
  - A channel granted at edge E is masked at edge E+1. This lets the requester drop `req` on seeing `gnt` without producing a double grant.
- **Channel load** (at the acceptance edge)
  - Start with `req_stop`=0 and period P≥1: count←P, scale/mode latched, active←1. This restarts any timer already running.
  - `req_stop`=1, or P==0: active←0, count←0.
- **Countdown**
  - Applies to an active channel on an edge where its selected strobe is high.
  - If count>1: count←count−1.
  - If count==1:
    - `expire[i]`←1 for the next cycle.
    - Periodic: count←latched P.
    - One-shot: active←0.
- **Priority:** a load at the same edge as a countdown tick wins. The tick is ignored for that channel and no expire is generated; a stop therefore suppresses a coincident expiry.
- Channels are independent. Several `expire` bits may pulse in the same cycle.

## Timing
- **Reset values:**
  - d0..d2 = 0, `ptr` = 0.
  - All channels inactive, count = 0.
  - `gnt`, `expire`, `busy` = 0.
  - `tick` = 4'b0001 (only t1 high).
- **Reset mid-operation:** all timers abort and no `expire` is issued. An outstanding request is not granted during reset.
- **Grant latency:** `gnt` is high in the cycle after the edge where the request is accepted. `busy` rises in that same cycle.
- **Expire timing:** it is high in the cycle after the P-th qualifying strobe edge following the load edge.
  - Scale 0: `expire` occurs exactly P cycles after the load edge.
  - Periodic scale 0: `expire` repeats every P cycles.
- **Scale >0:** the first period is shortened by the prescaler phase at load. It lasts between (P−1)·N+1 and P·N cycles, where N = 10/100/1000; later periods are exactly P·N.
- **Strobe spacing:** t1000 pulses once per 1000 cycles, first at the edge where d2d1d0 = 999, i.e. 999 cycles after reset release.

## Test plan
- **Reset and prescaler:** hold `reset` 3 cycles, release, run 3000 cycles.
  - t10 is high on every 10th cycle.
  - t100 is high on every 100th cycle.
  - t1000 is high on cycles 999, 1999, 2999.
  - Outputs are 0 during reset.
- **One-shot scale 0:** ch0, P=5, load at edge E.
  - `gnt[0]` is high in cycle E+1.
  - `expire[0]` is high in exactly one cycle, 5 cycles after E.
  - `busy[0]` then falls and there is no further expire.
- **Periodic /1000:** ch1, P=2. Expire pulses are exactly 2000 cycles apart after the first.
  - Then stop ch1 on the same edge as its final strobe: no expire, and `busy[1]` drops.
- **Arbitration:** all 4 `req` asserted together and held until their own `gnt`.
  - Grants go 0, 1, 2, 3 on consecutive cycles, one-hot.
  - A re-request from ch0 afterwards is granted before ch1 when `ptr`=0.
- **Edge cases:**
  - P=0 start on an active channel stops it.
  - Re-arming ch2 mid-count restarts it from the new P.
  - `reset` asserted while ch3 has count==1 produces no expire.
  - Wrap: with CNT_W=16, P=65535 at scale 0 expires after 65535 cycles.

Source files
------------

// File: rtl/tick_scheduler_if.sv
// Requester-facing bundle of tick_scheduler: configuration requests in,
// grant/expire/busy status and prescaler strobes out.
interface tick_scheduler_if #(
  parameter int NCH   = 4,
  parameter int CNT_W = 16
);
  logic [NCH-1:0]       req;
  logic [NCH*CNT_W-1:0] req_period;
  logic [NCH*2-1:0]     req_scale;
  logic [NCH-1:0]       req_mode;
  logic [NCH-1:0]       req_stop;
  logic [NCH-1:0]       gnt;
  logic [NCH-1:0]       expire;
  logic [NCH-1:0]       busy;
  logic [3:0]           tick;

  modport master (
    output req, req_period, req_scale, req_mode, req_stop,
    input  gnt, expire, busy, tick
  );

  modport slave (
    input  req, req_period, req_scale, req_mode, req_stop,
    output gnt, expire, busy, tick
  );
endinterface

// File: rtl/tick_scheduler.sv
// Multi-channel countdown timers sharing a free-running decade prescaler,
// configured through a single round-robin arbitrated request port.
module tick_scheduler #(
  parameter int NCH   = 4,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            reset,
  tick_scheduler_if.slave bus
);
  localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic [3:0]                d0_q, d1_q, d2_q, d0_d, d1_d, d2_d;
  logic                      t10, t100, t1000;
  logic [3:0]                tick_w;
  logic [PTR_W-1:0]          ptr_q, ptr_d;
  logic [NCH-1:0]            gnt_q, gnt_d;
  logic [NCH-1:0]            expire_q, expire_d;
  logic [NCH-1:0]            active_q, active_d;
  logic [NCH-1:0][CNT_W-1:0] count_q, count_d;
  logic [NCH-1:0][CNT_W-1:0] period_q, period_d;
  logic [NCH-1:0][1:0]       scale_q, scale_d;
  logic [NCH-1:0]            mode_q, mode_d;
  logic [NCH-1:0]            cand;
  logic                      sel_vld;
  logic [PTR_W-1:0]          sel_idx;

  always_comb begin
    t10    = (d0_q == 4'd9);
    t100   = t10 && (d1_q == 4'd9);
    t1000  = t100 && (d2_q == 4'd9);
    tick_w = {t1000, t100, t10, 1'b1};
    d0_d   = t10 ? 4'd0 : d0_q + 4'd1;
    d1_d   = d1_q;
    if (t10) d1_d = (d1_q == 4'd9) ? 4'd0 : d1_q + 4'd1;
    d2_d   = d2_q;
    if (t100) d2_d = (d2_q == 4'd9) ? 4'd0 : d2_q + 4'd1;
  end

  // The channel granted last edge is masked so a requester that drops req
  // one cycle after seeing gnt is not granted twice.
  always_comb begin
    cand    = bus.req & ~gnt_q;
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int k = 0; k < NCH; k++) begin
      int               j;
      logic [PTR_W-1:0] idx;
      j = int'(ptr_q) + k;
      if (j >= NCH) j = j - NCH;
      idx = PTR_W'(j);
      if (!sel_vld && cand[idx]) begin
        sel_vld = 1'b1;
        sel_idx = idx;
      end
    end
    gnt_d = '0;
    ptr_d = ptr_q;
    if (sel_vld) begin
      gnt_d[sel_idx] = 1'b1;
      ptr_d = (sel_idx == PTR_W'(NCH - 1)) ? '0 : sel_idx + 1'b1;
    end
  end

  // A load on the same edge as a countdown strobe takes precedence.
  always_comb begin
    active_d = active_q;
    count_d  = count_q;
    period_d = period_q;
    scale_d  = scale_q;
    mode_d   = mode_q;
    expire_d = '0;
    for (int i = 0; i < NCH; i++) begin
      logic [CNT_W-1:0] p;
      p = bus.req_period[i*CNT_W +: CNT_W];
      if (sel_vld && (sel_idx == PTR_W'(i))) begin
        if (bus.req_stop[i] || (p == '0)) begin
          active_d[i] = 1'b0;
          count_d[i]  = '0;
        end else begin
          active_d[i] = 1'b1;
          count_d[i]  = p;
          period_d[i] = p;
          scale_d[i]  = bus.req_scale[2*i +: 2];
          mode_d[i]   = bus.req_mode[i];
        end
      end else if (active_q[i] && tick_w[scale_q[i]]) begin
        if (count_q[i] > CNT_W'(1)) begin
          count_d[i] = count_q[i] - CNT_W'(1);
        end else begin
          expire_d[i] = 1'b1;
          if (mode_q[i]) begin
            count_d[i] = period_q[i];
          end else begin
            active_d[i] = 1'b0;
            count_d[i]  = '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d0_q     <= '0;
      d1_q     <= '0;
      d2_q     <= '0;
      ptr_q    <= '0;
      gnt_q    <= '0;
      expire_q <= '0;
      active_q <= '0;
      count_q  <= '0;
    end else begin
      d0_q     <= d0_d;
      d1_q     <= d1_d;
      d2_q     <= d2_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      expire_q <= expire_d;
      active_q <= active_d;
      count_q  <= count_d;
    end
  end

  // Latched configuration is only consulted while the channel is active.
  always_ff @(posedge clk) begin
    period_q <= period_d;
    scale_q  <= scale_d;
    mode_q   <= mode_d;
  end

  assign bus.gnt    = gnt_q;
  assign bus.expire = expire_q;
  assign bus.busy   = active_q;
  assign bus.tick   = tick_w;
endmodule

// File: tb/tb_tick_scheduler.sv
// Self-checking bench for tick_scheduler: directed steps plus random
// requests, scored against a closed-form timing model.
module tb_tick_scheduler;
  localparam int NCH   = 4;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic reset;

  tick_scheduler_if #(.NCH(NCH), .CNT_W(CNT_W)) bus ();
  tick_scheduler #(.NCH(NCH), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int     compared   = 0;
  int     mismatched = 0;
  longint cyc        = 0;
  bit     m_act [NCH];
  bit     m_per [NCH];
  longint m_next[NCH];
  longint m_step[NCH];
  int     m_ptr  = 0;
  int     m_last = -1;

  function automatic longint scale_n(int s);
    case (s)
      0:       return 1;
      1:       return 10;
      2:       return 100;
      default: return 1000;
    endcase
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_fields(int ch, int p, int s, bit md, bit st);
    bus.req_period[ch*CNT_W +: CNT_W] = CNT_W'(p);
    bus.req_scale[2*ch +: 2]          = 2'(s);
    bus.req_mode[ch]                  = md;
    bus.req_stop[ch]                  = st;
  endtask

  // Model: cycle c ends with the edge where strobe /N fires iff c%N==N-1.
  task automatic run_cycle();
    logic [NCH-1:0] e_gnt, e_exp, e_busy;
    logic [3:0]     e_tick;
    longint         nxt, n, p, q;
    int             sel, j;
    e_gnt = '0;
    e_exp = '0;
    if (reset) begin
      for (int i = 0; i < NCH; i++) m_act[i] = 1'b0;
      m_ptr  = 0;
      m_last = -1;
      nxt    = 0;
    end else begin
      for (int i = 0; i < NCH; i++)
        if (m_act[i] && m_next[i] == cyc) begin
          e_exp[i] = 1'b1;
          if (m_per[i]) m_next[i] += m_step[i];
          else m_act[i] = 1'b0;
        end
      sel = -1;
      for (int k = 0; k < NCH; k++) begin
        j = (m_ptr + k) % NCH;
        if (sel < 0 && bus.req[j] && j != m_last) sel = j;
      end
      m_last = sel;
      if (sel >= 0) begin
        n = scale_n(int'(bus.req_scale[2*sel +: 2]));
        p = longint'(bus.req_period[sel*CNT_W +: CNT_W]);
        e_gnt[sel] = 1'b1;
        e_exp[sel] = 1'b0;
        m_ptr = (sel + 1) % NCH;
        if (bus.req_stop[sel] || p == 0) begin
          m_act[sel] = 1'b0;
        end else begin
          q = cyc + 1 + (n - 1 - ((cyc + 1) % n));
          m_act[sel]  = 1'b1;
          m_next[sel] = q + (p - 1) * n;
          m_step[sel] = p * n;
          m_per[sel]  = bus.req_mode[sel];
        end
      end
      nxt = cyc + 1;
    end
    @(posedge clk);
    @(negedge clk);
    cyc = nxt;
    for (int i = 0; i < NCH; i++) e_busy[i] = m_act[i];
    e_tick = {(cyc % 1000) == 999, (cyc % 100) == 99, (cyc % 10) == 9, 1'b1};
    chk("gnt", 64'(bus.gnt), 64'(e_gnt));
    chk("expire", 64'(bus.expire), 64'(e_exp));
    chk("busy", 64'(bus.busy), 64'(e_busy));
    chk("tick", 64'(bus.tick), 64'(e_tick));
  endtask

  task automatic request(int ch, int p, int s, bit md, bit st);
    bit got;
    got = 1'b0;
    set_fields(ch, p, s, md, st);
    bus.req[ch] = 1'b1;
    for (int k = 0; k < 64 && !got; k++) begin
      run_cycle();
      if (bus.gnt[ch]) got = 1'b1;
    end
    bus.req[ch] = 1'b0;
    chk("gnt_wait", 64'(got), 64'd1);
  endtask

  initial begin
    int     npulse, at;
    longint pulses[8];
    int     g_ord[4];
    longint g_cyc[4];
    int     ng, first;
    bit     pend[NCH];
    bit     late[NCH];

    reset          = 1'b1;
    bus.req        = '0;
    bus.req_period = '0;
    bus.req_scale  = '0;
    bus.req_mode   = '0;
    bus.req_stop   = '0;
    for (int i = 0; i < NCH; i++) begin
      pend[i] = 1'b0;
      late[i] = 1'b0;
    end

    // reset and free-running prescaler
    repeat (3) run_cycle();
    reset = 1'b0;
    repeat (3000) run_cycle();

    // one-shot, scale 0, P=5
    request(0, 5, 0, 1'b0, 1'b0);
    npulse = 0;
    at     = 0;
    for (int k = 1; k <= 12; k++) begin
      run_cycle();
      if (bus.expire[0]) begin
        npulse++;
        at = k;
      end
    end
    chk("oneshot_pulses", 64'(npulse), 64'd1);
    chk("oneshot_delay", 64'(at), 64'd5);
    chk("oneshot_busy", 64'(bus.busy[0]), 64'd0);

    // periodic /1000, P=2
    request(1, 2, 3, 1'b1, 1'b0);
    npulse = 0;
    for (int k = 0; k < 6100; k++) begin
      run_cycle();
      if (bus.expire[1] && npulse < 8) begin
        pulses[npulse] = cyc;
        npulse++;
      end
    end
    chk("periodic_count", 64'(npulse >= 3), 64'd1);
    chk("periodic_gap1", 64'(pulses[1] - pulses[0]), 64'd2000);
    chk("periodic_gap2", 64'(pulses[2] - pulses[1]), 64'd2000);
    for (int k = 0; k < 2100 && cyc != m_next[1]; k++) run_cycle();
    request(1, 0, 0, 1'b0, 1'b1);
    chk("stop_no_expire", 64'(bus.expire[1]), 64'd0);
    chk("stop_busy", 64'(bus.busy[1]), 64'd0);

    // P=0 start on an active channel
    request(2, 200, 1, 1'b1, 1'b0);
    repeat (30) run_cycle();
    chk("p0_armed", 64'(bus.busy[2]), 64'd1);
    request(2, 0, 2, 1'b1, 1'b0);
    chk("p0_busy", 64'(bus.busy[2]), 64'd0);

    // re-arm mid-count
    request(2, 50, 0, 1'b0, 1'b0);
    repeat (20) run_cycle();
    request(2, 30, 0, 1'b0, 1'b0);
    first = 0;
    for (int k = 1; k <= 40; k++) begin
      run_cycle();
      if (bus.expire[2] && first == 0) first = k;
    end
    chk("rearm_delay", 64'(first), 64'd30);

    // reset while ch3 is on its final count
    request(3, 10, 0, 1'b0, 1'b0);
    for (int k = 0; k < 20 && cyc != m_next[3]; k++) run_cycle();
    reset = 1'b1;
    set_fields(0, 4, 0, 1'b0, 1'b0);
    bus.req[0] = 1'b1;
    run_cycle();
    chk("rst_no_expire", 64'(bus.expire[3]), 64'd0);
    chk("rst_no_gnt", 64'(bus.gnt), 64'd0);
    run_cycle();
    chk("rst_busy", 64'(bus.busy), 64'd0);
    bus.req[0] = 1'b0;
    reset = 1'b0;
    repeat (5) run_cycle();

    // arbitration: all request together, each drops one cycle after its gnt
    for (int i = 0; i < NCH; i++) set_fields(i, 3 + i, 0, 1'b0, 1'b0);
    bus.req = '1;
    ng = 0;
    for (int t = 0; t < 20 && (ng < 4 || bus.req != '0); t++) begin
      run_cycle();
      if (bus.gnt != '0) begin
        chk("arb_onehot", 64'($countones(bus.gnt)), 64'd1);
        if (ng < 4) begin
          for (int i = 0; i < NCH; i++) if (bus.gnt[i]) g_ord[ng] = i;
          g_cyc[ng] = cyc;
        end
        ng++;
      end
      for (int i = 0; i < NCH; i++) begin
        if (pend[i]) begin
          bus.req[i] = 1'b0;
          pend[i]    = 1'b0;
        end else if (bus.req[i] && bus.gnt[i]) begin
          pend[i] = 1'b1;
        end
      end
    end
    chk("arb_count", 64'(ng), 64'd4);
    for (int i = 0; i < 4; i++) chk("arb_order", 64'(g_ord[i]), 64'(i));
    for (int i = 1; i < 4; i++) chk("arb_consecutive", 64'(g_cyc[i] - g_cyc[i-1]), 64'd1);
    set_fields(0, 7, 0, 1'b0, 1'b0);
    set_fields(1, 7, 0, 1'b0, 1'b0);
    bus.req[1:0] = 2'b11;
    first = -1;
    for (int t = 0; t < 10 && bus.req[1:0] != 2'b00; t++) begin
      run_cycle();
      for (int i = 0; i < 2; i++)
        if (bus.gnt[i]) begin
          if (first < 0) first = i;
          bus.req[i] = 1'b0;
        end
    end
    bus.req = '0;
    chk("arb_rerequest_first", 64'(first), 64'd0);

    // random requests with mixed immediate and late drop of req
    for (int t = 0; t < 2000; t++) begin
      run_cycle();
      for (int i = 0; i < NCH; i++) begin
        if (pend[i]) begin
          bus.req[i] = 1'b0;
          pend[i]    = 1'b0;
        end else if (bus.req[i] && bus.gnt[i]) begin
          if (late[i]) pend[i] = 1'b1;
          else bus.req[i] = 1'b0;
        end else if (!bus.req[i] && $urandom_range(0, 5) == 0) begin
          set_fields(i, ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 20)),
                     int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 7) == 0));
          late[i]    = 1'($urandom_range(0, 1));
          bus.req[i] = 1'b1;
        end
      end
    end
    bus.req = '0;
    repeat (3) run_cycle();

    // full-range period at scale 0
    request(0, 65535, 0, 1'b0, 1'b0);
    first = 0;
    for (int k = 1; k <= 65540; k++) begin
      run_cycle();
      if (bus.expire[0] && first == 0) first = k;
    end
    chk("wrap_delay", 64'(first), 64'd65535);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
